// File: rtl/mul_div_sequencer_if.sv
// Handshake and result bundle between the pipeline/hazard logic and the
// iterative multiply/divide sequencer.
interface mul_div_sequencer_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        flush;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] result;
  logic [31:0] y_out;
  logic        N;
  logic        Z;
  logic        V;
  logic        C;
  logic        div_zero;

  modport master (
    output start, op, A, B, flush,
    input  busy, stall, done, result, y_out, N, Z, V, C, div_zero
  );

  modport slave (
    input  start, op, A, B, flush,
    output busy, stall, done, result, y_out, N, Z, V, C, div_zero
  );
endinterface

// File: rtl/mul_div_sequencer.sv
// Iterative 32x32 multiply / 32/32 divide sequencer: one radix-2 step per cycle,
// operating on magnitudes, with the sign fix-up applied in a final cycle.
module mul_div_sequencer (
  input  logic                 clk,
  input  logic                 R,
  mul_div_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] m_q, m_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] rem_q, rem_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        res_sign_q, res_sign_d;
  logic        rem_sign_q, rem_sign_d;
  logic [31:0] result_q, result_d;
  logic [31:0] y_q, y_d;
  logic        n_q, n_d;
  logic        z_q, z_d;
  logic        v_q, v_d;
  logic        dz_q, dz_d;

  logic [31:0] a_abs, b_abs;
  logic [32:0] mul_sum;
  logic [32:0] div_trial;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;
  logic        clamp;
  logic        busy_w;

  assign a_abs = (op_q[0] && a_q[31]) ? -a_q : a_q;
  assign b_abs = (op_q[0] && b_q[31]) ? -b_q : b_q;

  // Multiply: acc holds {partial product, remaining multiplier bits}; divide:
  // acc[31:0] shifts the dividend out at the top and quotient bits in at the bottom.
  assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, m_q} : 33'd0);
  assign div_trial = {rem_q, acc_q[31]} - {1'b0, m_q};

  assign prod_fix = res_sign_q ? -acc_q : acc_q;
  assign quo_fix  = res_sign_q ? -acc_q[31:0] : acc_q[31:0];
  assign rem_fix  = rem_sign_q ? -rem_q : rem_q;
  // Only -2^31 / -1 yields a positive quotient magnitude of 2^31.
  assign clamp    = (op_q == 2'b11) && !res_sign_q && acc_q[31];

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    m_d        = m_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    res_sign_d = res_sign_q;
    rem_sign_d = rem_sign_q;
    result_d   = result_q;
    y_d        = y_q;
    n_d        = n_q;
    z_d        = z_q;
    v_d        = v_q;
    dz_d       = dz_q;

    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            op_d    = bus.op;
            a_d     = bus.A;
            b_d     = bus.B;
            state_d = PREP;
          end
        end
        PREP: begin
          res_sign_d = op_q[0] && (a_q[31] ^ b_q[31]);
          rem_sign_d = op_q[0] && a_q[31];
          cnt_d      = 6'd0;
          rem_d      = 32'd0;
          if (op_q[1] && (b_q == 32'd0)) begin
            result_d = 32'hFFFF_FFFF;
            y_d      = a_q;
            n_d      = 1'b1;
            z_d      = 1'b0;
            v_d      = 1'b1;
            dz_d     = 1'b1;
            state_d  = DONE;
          end else begin
            m_d     = op_q[1] ? b_abs : a_abs;
            acc_d   = {32'd0, (op_q[1] ? a_abs : b_abs)};
            state_d = RUN;
          end
        end
        RUN: begin
          cnt_d = cnt_q + 6'd1;
          if (op_q[1]) begin
            acc_d = {acc_q[63:32], acc_q[30:0], ~div_trial[32]};
            rem_d = div_trial[32] ? {rem_q[30:0], acc_q[31]} : div_trial[31:0];
          end else begin
            acc_d = {mul_sum, acc_q[31:1]};
          end
          if (cnt_q == 6'd31) begin
            state_d = FIX;
          end
        end
        FIX: begin
          v_d  = 1'b0;
          dz_d = 1'b0;
          if (!op_q[1]) begin
            result_d = prod_fix[31:0];
            y_d      = prod_fix[63:32];
          end else if (clamp) begin
            result_d = 32'h7FFF_FFFF;
            y_d      = 32'd0;
            v_d      = 1'b1;
          end else begin
            result_d = quo_fix;
            y_d      = rem_fix;
          end
          n_d     = result_d[31];
          z_d     = (result_d == 32'd0);
          state_d = DONE;
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state_q    <= IDLE;
      op_q       <= 2'd0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      m_q        <= 32'd0;
      acc_q      <= 64'd0;
      rem_q      <= 32'd0;
      cnt_q      <= 6'd0;
      res_sign_q <= 1'b0;
      rem_sign_q <= 1'b0;
      result_q   <= 32'd0;
      y_q        <= 32'd0;
      n_q        <= 1'b0;
      z_q        <= 1'b0;
      v_q        <= 1'b0;
      dz_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      m_q        <= m_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      res_sign_q <= res_sign_d;
      rem_sign_q <= rem_sign_d;
      result_q   <= result_d;
      y_q        <= y_d;
      n_q        <= n_d;
      z_q        <= z_d;
      v_q        <= v_d;
      dz_q       <= dz_d;
    end
  end

  assign busy_w = (state_q == PREP) || (state_q == RUN) || (state_q == FIX);

  // Gated by R so a held start cannot raise stall while in reset.
  assign bus.stall    = R && (busy_w || ((state_q == IDLE) && bus.start));
  assign bus.busy     = busy_w;
  assign bus.done     = (state_q == DONE);
  assign bus.result   = result_q;
  assign bus.y_out    = y_q;
  assign bus.N        = n_q;
  assign bus.Z        = z_q;
  assign bus.V        = v_q;
  assign bus.C        = 1'b0;
  assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Bench for mul_div_sequencer: directed corner cases plus random operations
// checked against an arithmetic reference model.
module tb_mul_div_sequencer;

  logic clk = 1'b0;
  logic R;
  int   n_compared = 0;
  int   n_mismatched = 0;

  mul_div_sequencer_if bus();

  mul_div_sequencer dut (
    .clk (clk),
    .R   (R),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference behaviour from plain integer arithmetic.
  task automatic modelOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic [31:0] y,
                         output logic v, output logic dz, output int lat);
    longint sa, sb, sq, sr;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    r   = 32'd0;
    y   = 32'd0;
    v   = 1'b0;
    dz  = 1'b0;
    lat = 34;
    case (op)
      2'b00: begin
        p = {32'd0, a} * {32'd0, b};
        r = p[31:0];
        y = p[63:32];
      end
      2'b01: begin
        p = sa * sb;
        r = p[31:0];
        y = p[63:32];
      end
      default: begin
        if (b == 32'd0) begin
          r = 32'hFFFF_FFFF; y = a; v = 1'b1; dz = 1'b1; lat = 1;
        end else if (op == 2'b10) begin
          r = a / b;
          y = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          r = 32'h7FFF_FFFF; y = 32'd0; v = 1'b1;
        end else begin
          sq = sa / sb;
          sr = sa % sb;
          r = sq[31:0];
          y = sr[31:0];
        end
      end
    endcase
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.op    = op;
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    #1;
    checkOutput("stall_idle_start", bus.stall, 1);
    checkOutput("busy_idle_start", bus.busy, 0);
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic waitDone(input int limit, output int lat, output int busy_cycles);
    lat = 0;
    busy_cycles = 0;
    @(negedge clk);
    while (bus.done !== 1'b1 && lat < limit) begin
      if (bus.busy === 1'b1 && bus.stall === 1'b1) busy_cycles++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic checkResult(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                             input int lat, input int busy_cycles, input int skipped);
    logic [31:0] r, y;
    logic v, dz;
    int el;
    modelOp(op, a, b, r, y, v, dz, el);
    checkOutput("latency", lat, el - skipped);
    checkOutput("busy_cycles", busy_cycles, el - skipped);
    checkOutput("done", bus.done, 1);
    checkOutput("result", bus.result, r);
    checkOutput("y_out", bus.y_out, y);
    checkOutput("N", bus.N, r[31]);
    checkOutput("Z", bus.Z, (r == 32'd0));
    checkOutput("V", bus.V, v);
    checkOutput("C", bus.C, 0);
    checkOutput("div_zero", bus.div_zero, dz);
    checkOutput("stall_in_done", bus.stall, 0);
    @(negedge clk);
    checkOutput("done_width", bus.done, 0);
    checkOutput("idle_after_done", bus.busy, 0);
    checkOutput("result_hold", bus.result, r);
  endtask

  initial begin
    int lat, bc, done_seen;
    logic [1:0] rop;
    logic [31:0] ra, rb;

    R = 1'b0;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op = 2'b00;
    bus.A = 32'd0;
    bus.B = 32'd0;
    #2;
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_stall", bus.stall, 0);
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_result", bus.result, 0);
    checkOutput("rst_y_out", bus.y_out, 0);
    checkOutput("rst_flags", {bus.N, bus.Z, bus.V, bus.C}, 0);
    checkOutput("rst_div_zero", bus.div_zero, 0);
    @(negedge clk);
    R = 1'b1;

    applyStimulus(2'b00, 32'hFFFF_FFFF, 32'd2);
    waitDone(60, lat, bc);
    checkResult(2'b00, 32'hFFFF_FFFF, 32'd2, lat, bc, 0);
    checkOutput("umul_result", bus.result, 32'hFFFF_FFFE);
    checkOutput("umul_y_out", bus.y_out, 32'd1);

    applyStimulus(2'b01, -32'sd3, 32'd7);
    waitDone(60, lat, bc);
    checkResult(2'b01, -32'sd3, 32'd7, lat, bc, 0);
    checkOutput("smul_result", bus.result, 32'hFFFF_FFEB);
    checkOutput("smul_y_out", bus.y_out, 32'hFFFF_FFFF);

    // A second start at E0+5 must not disturb the running divide.
    applyStimulus(2'b11, -32'sd17, 32'd5);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 2'b00;
    bus.A = 32'd9;
    bus.B = 32'd9;
    @(posedge clk);
    #1 bus.start = 1'b0;
    waitDone(60, lat, bc);
    checkResult(2'b11, -32'sd17, 32'd5, lat, bc, 5);
    checkOutput("sdiv_result", bus.result, 32'hFFFF_FFFD);
    checkOutput("sdiv_y_out", bus.y_out, 32'hFFFF_FFFE);

    applyStimulus(2'b10, 32'd100, 32'd7);
    waitDone(60, lat, bc);
    checkResult(2'b10, 32'd100, 32'd7, lat, bc, 0);
    checkOutput("udiv_result", bus.result, 32'd14);
    checkOutput("udiv_y_out", bus.y_out, 32'd2);

    // Flush at E0+10: back to IDLE, no done, outputs keep 14 / 2.
    applyStimulus(2'b10, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_busy", bus.busy, 0);
    checkOutput("flush_stall", bus.stall, 0);
    checkOutput("flush_result", bus.result, 32'd14);
    checkOutput("flush_y_out", bus.y_out, 32'd2);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_seen++;
    end
    checkOutput("flush_no_done", done_seen, 0);

    applyStimulus(2'b10, 32'h1234_5678, 32'd0);
    waitDone(60, lat, bc);
    checkResult(2'b10, 32'h1234_5678, 32'd0, lat, bc, 0);
    checkOutput("udiv0_result", bus.result, 32'hFFFF_FFFF);

    applyStimulus(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    waitDone(60, lat, bc);
    checkResult(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc, 0);
    checkOutput("clamp_result", bus.result, 32'h7FFF_FFFF);
    checkOutput("clamp_V", bus.V, 1);

    for (int i = 0; i < 12; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (i % 3 == 1) rb = $urandom_range(1, 20);
      if (i % 4 == 3) rb = 32'd0;
      if (i % 5 == 2) ra = 32'h8000_0000;
      applyStimulus(rop, ra, rb);
      waitDone(60, lat, bc);
      checkResult(rop, ra, rb, lat, bc, 0);
    end

    // Asynchronous reset in the middle of RUN.
    applyStimulus(2'b00, 32'd5, 32'd6);
    repeat (10) @(posedge clk);
    #2 R = 1'b0;
    #1;
    checkOutput("midrst_busy", bus.busy, 0);
    checkOutput("midrst_stall", bus.stall, 0);
    checkOutput("midrst_done", bus.done, 0);
    checkOutput("midrst_result", bus.result, 0);
    checkOutput("midrst_y_out", bus.y_out, 0);
    checkOutput("midrst_flags", {bus.N, bus.Z, bus.V, bus.C, bus.div_zero}, 0);
    @(negedge clk);
    @(negedge clk);
    R = 1'b1;
    applyStimulus(2'b00, 32'd3, 32'd4);
    waitDone(60, lat, bc);
    checkResult(2'b00, 32'd3, 32'd4, lat, bc, 0);
    checkOutput("post_rst_result", bus.result, 32'd12);

    // flush together with start in IDLE keeps the block idle.
    @(negedge clk);
    bus.op = 2'b00;
    bus.A = 32'd7;
    bus.B = 32'd9;
    bus.start = 1'b1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_start_busy", bus.busy, 0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_seen++;
    end
    checkOutput("flush_start_no_done", done_seen, 0);
    checkOutput("flush_start_hold", bus.result, 32'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
